hs32_mem_arb: RTL and testbench
===============================

# hs32_mem_arb

Two-master arbiter placed directly upstream of the BRAM controller's single strobe/ack port. It serialises requests from the HS32 CPU memory port (single-cycle strobe) and the Caravel Wishbone host (classic cyc/stb held until ack) onto that port. It holds address and write data stable for the whole slave transaction and returns read data and ack to the granted master. It also provides round-robin fairness, a one-deep CPU pending buffer and a slave-ack timeout.

## Interface
- addr_width, 12, byte address width on all three ports
- timeout, 15, cycles waited in WAIT for s_ack before error completion (1..255)

- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_a_addr  in  addr_width  CPU address
- i_a_dwrite  in  32  CPU write data
- i_a_rw  in  1  CPU 1=write, 0=read
- i_a_stb  in  1  CPU request, one-cycle pulse
- o_a_dread  out  32  CPU read data, valid with o_a_ack
- o_a_ack  out  1  CPU completion pulse
- o_a_err  out  1  CPU timeout flag, valid with o_a_ack
- o_a_ovf  out  1  pulse: CPU strobe dropped (pending already full)
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone classic controls
- i_wb_adr  in  addr_width  Wishbone address
- i_wb_dat  in  32  Wishbone write data
- o_wb_dat  out  32  Wishbone read data
- o_wb_ack  out  1  Wishbone ack pulse
- o_s_addr  out  addr_width  slave address
- o_s_dwrite  out  32  slave write data
- o_s_rw  out  1  slave 1=write
- o_s_stb  out  1  slave strobe
- i_s_ack  in  1  slave ack
- i_s_dread  in  32  slave read data, valid while i_s_ack=1

## Operation
- States: IDLE, REQ, WAIT. Reset → IDLE, last_grant=WB, pending empty, timeout counter 0. Every output register resets to 0.
- CPU request source: i_a_stb this cycle, else pending buffer. i_a_stb not granted at its sampling edge is stored in pending (addr, data, rw).
- i_a_stb while pending already valid: new strobe dropped, pending unchanged, o_a_ovf=1 for one cycle.
- WB request = i_wb_cyc & i_wb_stb & !o_wb_ack. The mask prevents a re-grant in the ack cycle.
- IDLE: if only one master requests, grant it. If both request, grant the one ≠ last_grant and update last_grant. Granting latches o_s_addr/o_s_dwrite/o_s_rw from the winner and goes to REQ. A granted pending entry is cleared.
- REQ: o_s_stb=1 for exactly this cycle; go to WAIT and clear the counter.
- WAIT: o_s_* held stable, o_s_stb=0.
  - On i_s_ack: capture i_s_dread into the winner's read-data register and pulse the winner's ack next cycle; return to IDLE.
  - Counter reaching timeout without ack: pulse ack with read data 0. o_a_err=1 if the winner is the CPU; Wishbone gets a plain ack. Return to IDLE.
- i_s_ack outside WAIT is ignored.
- WB master drops i_wb_cyc mid-transaction: slave transaction completes, o_wb_ack is suppressed.
- o_wb_dat/o_a_dread hold their last value until the next completion.

## Timing
- CPU uncontended: strobe in cycle 0, o_s_stb in cycle 1, bram ack in cycle 2, o_a_ack + data in cycle 3. The arbiter is back in IDLE in cycle 3, so the next o_s_stb is in cycle 4 at the earliest.
- Wishbone: same 3-cycle latency from first cycle stb is high.
- Simultaneous CPU strobe and WB request after reset: CPU first (last_grant=WB). WB is served 3 cycles later; the CPU is then granted again only if it has a new or pending request.
- Error completion: o_a_ack in the cycle after the timeout-th WAIT cycle.
- Async reset mid-transaction: immediate return to IDLE, outputs 0, in-flight request abandoned with no ack.

## Structure
- Shared package hs32_mem_arb_pkg: state encoding (IDLE/REQ/WAIT), grant IDs (GNT_CPU, GNT_WB), timeout counter width constant (8).
- One sub-module: hs32_arb_pend. It is the one-deep CPU pending register with a valid bit and the overflow pulse.

## Test plan
- CPU read 0x104, slave returns 0xDEADBEEF on ack → o_s_stb in cycle 1, o_a_ack + o_a_dread=0xDEADBEEF in cycle 3, o_a_err=0.
- CPU write 0x020 and WB read 0x040 in the same cycle after reset → CPU granted first (o_s_addr=0x020, o_s_rw=1), then WB (o_s_addr=0x040, o_s_rw=0). Exactly one ack each.
- Continuous WB stream plus CPU strobes every cycle → grants strictly alternate. A second CPU strobe while pending is valid raises o_a_ovf for one cycle.
- Slave never acks, timeout=15 → o_a_ack=1, o_a_err=1, o_a_dread=0 after 15 WAIT cycles, then IDLE.
- WB host drops i_wb_cyc in the WAIT cycle → slave ack consumed, o_wb_ack stays 0, next request served normally.
- Assert i_reset_n=0 during WAIT → all outputs 0 immediately, no ack after release, last_grant=WB.

Source files
------------

// File: rtl/hs32_mem_arb_pkg.sv
// Shared encodings for the HS32 memory arbiter: FSM states, grant IDs, timeout counter width.
// Combinational constants only.
package hs32_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_WB  = 1'b1;

  localparam int TO_W = 8;
  typedef logic [TO_W-1:0] to_cnt_t;

endpackage

// File: rtl/hs32_mem_arb_if.sv
// Bundle of CPU, Wishbone and BRAM-side signals around the arbiter.
// slave = the arbiter's view; master = the requesters and the BRAM that face it.
interface hs32_mem_arb_if #(
  parameter int addr_width = 12
);
  logic [addr_width-1:0] i_a_addr;
  logic [31:0]           i_a_dwrite;
  logic                  i_a_rw;
  logic                  i_a_stb;
  logic [31:0]           o_a_dread;
  logic                  o_a_ack;
  logic                  o_a_err;
  logic                  o_a_ovf;

  logic                  i_wb_cyc;
  logic                  i_wb_stb;
  logic                  i_wb_we;
  logic [addr_width-1:0] i_wb_adr;
  logic [31:0]           i_wb_dat;
  logic [31:0]           o_wb_dat;
  logic                  o_wb_ack;

  logic [addr_width-1:0] o_s_addr;
  logic [31:0]           o_s_dwrite;
  logic                  o_s_rw;
  logic                  o_s_stb;
  logic                  i_s_ack;
  logic [31:0]           i_s_dread;

  modport slave (
    input  i_a_addr, i_a_dwrite, i_a_rw, i_a_stb,
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    input  i_s_ack, i_s_dread,
    output o_a_dread, o_a_ack, o_a_err, o_a_ovf,
    output o_wb_dat, o_wb_ack,
    output o_s_addr, o_s_dwrite, o_s_rw, o_s_stb
  );

  modport master (
    output i_a_addr, i_a_dwrite, i_a_rw, i_a_stb,
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    output i_s_ack, i_s_dread,
    input  o_a_dread, o_a_ack, o_a_err, o_a_ovf,
    input  o_wb_dat, o_wb_ack,
    input  o_s_addr, o_s_dwrite, o_s_rw, o_s_stb
  );
endinterface

// File: rtl/hs32_arb_pend.sv
// One-deep holding register for a CPU strobe that lost arbitration; presents strobe-or-pending as the CPU request.
// Zero-latency bypass; a strobe arriving while full is dropped and flagged on o_ovf the next cycle.
module hs32_arb_pend #(
  parameter int addr_width = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_stb,
  input  logic [addr_width-1:0] i_addr,
  input  logic [31:0]           i_dwrite,
  input  logic                  i_rw,
  input  logic                  i_take,
  output logic                  o_req,
  output logic [addr_width-1:0] o_addr,
  output logic [31:0]           o_dwrite,
  output logic                  o_rw,
  output logic                  o_ovf
);
  logic                  vld;
  logic [addr_width-1:0] addr_q;
  logic [31:0]           dwrite_q;
  logic                  rw_q;

  // The held entry is older than any new strobe, so it always takes priority.
  assign o_req    = vld | i_stb;
  assign o_addr   = vld ? addr_q   : i_addr;
  assign o_dwrite = vld ? dwrite_q : i_dwrite;
  assign o_rw     = vld ? rw_q     : i_rw;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld      <= 1'b0;
      addr_q   <= '0;
      dwrite_q <= '0;
      rw_q     <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_ovf <= vld & i_stb;
      if (vld) begin
        if (i_take) vld <= 1'b0;
      end else if (i_stb && !i_take) begin
        vld      <= 1'b1;
        addr_q   <= i_addr;
        dwrite_q <= i_dwrite;
        rw_q     <= i_rw;
      end
    end
  end
endmodule

// File: rtl/hs32_mem_arb.sv
// Round-robin arbiter serialising HS32 CPU and Wishbone requests onto one BRAM strobe/ack port.
// Latency: request edge -> o_s_stb next cycle -> ack one cycle after slave ack; slave stalls bounded by timeout.
module hs32_mem_arb #(
  parameter int addr_width = 12,
  parameter int timeout    = 15
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  hs32_mem_arb_if.slave      bus
);
  import hs32_mem_arb_pkg::*;

  logic [1:0]            state;
  logic                  last_grant;
  to_cnt_t               cnt;
  logic                  wb_drop;

  logic                  cpu_req;
  logic [addr_width-1:0] cpu_addr;
  logic [31:0]           cpu_dwrite;
  logic                  cpu_rw;
  logic                  wb_req;
  logic                  grant_cpu;
  logic                  grant_wb;
  logic                  done;
  logic [31:0]           s_rdata;

  hs32_arb_pend #(.addr_width(addr_width)) u_pend (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_stb    (bus.i_a_stb),
    .i_addr   (bus.i_a_addr),
    .i_dwrite (bus.i_a_dwrite),
    .i_rw     (bus.i_a_rw),
    .i_take   (grant_cpu),
    .o_req    (cpu_req),
    .o_addr   (cpu_addr),
    .o_dwrite (cpu_dwrite),
    .o_rw     (cpu_rw),
    .o_ovf    (bus.o_a_ovf)
  );

  // Masking with o_wb_ack stops the still-high stb from re-granting in the ack cycle.
  assign wb_req    = bus.i_wb_cyc & bus.i_wb_stb & ~bus.o_wb_ack;
  assign grant_cpu = (state == ST_IDLE) & cpu_req & (~wb_req | (last_grant == GNT_WB));
  assign grant_wb  = (state == ST_IDLE) & wb_req & ~grant_cpu;
  assign done      = (state == ST_WAIT) & (bus.i_s_ack | (cnt == TO_W'(timeout - 1)));
  assign s_rdata   = bus.i_s_ack ? bus.i_s_dread : 32'h0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_IDLE;
      last_grant     <= GNT_WB;
      cnt            <= '0;
      wb_drop        <= 1'b0;
      bus.o_s_addr   <= '0;
      bus.o_s_dwrite <= '0;
      bus.o_s_rw     <= 1'b0;
      bus.o_s_stb    <= 1'b0;
      bus.o_a_dread  <= '0;
      bus.o_a_ack    <= 1'b0;
      bus.o_a_err    <= 1'b0;
      bus.o_wb_dat   <= '0;
      bus.o_wb_ack   <= 1'b0;
    end else begin
      bus.o_a_ack  <= 1'b0;
      bus.o_a_err  <= 1'b0;
      bus.o_wb_ack <= 1'b0;
      // A host that abandons its cycle mid-flight must never see the late ack.
      if (state != ST_IDLE && last_grant == GNT_WB && !bus.i_wb_cyc) wb_drop <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (grant_cpu || grant_wb) begin
            state          <= ST_REQ;
            bus.o_s_stb    <= 1'b1;
            wb_drop        <= 1'b0;
            last_grant     <= grant_wb ? GNT_WB : GNT_CPU;
            bus.o_s_addr   <= grant_wb ? bus.i_wb_adr : cpu_addr;
            bus.o_s_dwrite <= grant_wb ? bus.i_wb_dat : cpu_dwrite;
            bus.o_s_rw     <= grant_wb ? bus.i_wb_we  : cpu_rw;
          end
        end
        ST_REQ: begin
          bus.o_s_stb <= 1'b0;
          cnt         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state <= ST_IDLE;
            if (last_grant == GNT_CPU) begin
              bus.o_a_ack   <= 1'b1;
              bus.o_a_err   <= ~bus.i_s_ack;
              bus.o_a_dread <= s_rdata;
            end else begin
              bus.o_wb_ack <= bus.i_wb_cyc & ~wb_drop;
              bus.o_wb_dat <= s_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hs32_mem_arb.sv
// Scoreboard bench for hs32_mem_arb: directed CPU/WB traffic against a one-cycle-ack BRAM model.
// Expected slave strobes, acks and overflow pulses are queued by stimulus and popped by a monitor.
module tb_hs32_mem_arb;

  typedef struct { logic [11:0] addr; logic [31:0] wdat; logic rw; int cyc; } s_exp_t;
  typedef struct { logic [31:0] dat; logic err; int cyc; } a_exp_t;
  typedef struct { logic [31:0] dat; int cyc; } w_exp_t;

  logic i_clk;
  logic i_reset_n;
  int   cyc;
  int   total;
  int   bad;
  logic bram_on;
  int   spur_cnt;

  s_exp_t s_q[$];
  a_exp_t a_q[$];
  w_exp_t w_q[$];
  int     ovf_q[$];

  hs32_mem_arb_if #(.addr_width(12)) bus ();

  hs32_mem_arb #(.addr_width(12), .timeout(15)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " o_s_addr"},   64'(bus.o_s_addr),   64'h0);
    chk({tag, " o_s_dwrite"}, 64'(bus.o_s_dwrite), 64'h0);
    chk({tag, " o_s_rw"},     64'(bus.o_s_rw),     64'h0);
    chk({tag, " o_s_stb"},    64'(bus.o_s_stb),    64'h0);
    chk({tag, " o_a_dread"},  64'(bus.o_a_dread),  64'h0);
    chk({tag, " o_a_ack"},    64'(bus.o_a_ack),    64'h0);
    chk({tag, " o_a_err"},    64'(bus.o_a_err),    64'h0);
    chk({tag, " o_a_ovf"},    64'(bus.o_a_ovf),    64'h0);
    chk({tag, " o_wb_dat"},   64'(bus.o_wb_dat),   64'h0);
    chk({tag, " o_wb_ack"},   64'(bus.o_wb_ack),   64'h0);
  endtask

  task automatic push_s(input logic [11:0] a, input logic [31:0] d, input logic rw, input int c);
    s_exp_t e;
    e.addr = a; e.wdat = d; e.rw = rw; e.cyc = c;
    s_q.push_back(e);
  endtask

  task automatic push_a(input logic [31:0] d, input logic err, input int c);
    a_exp_t e;
    e.dat = d; e.err = err; e.cyc = c;
    a_q.push_back(e);
  endtask

  task automatic push_w(input logic [31:0] d, input int c);
    w_exp_t e;
    e.dat = d; e.cyc = c;
    w_q.push_back(e);
  endtask

  task automatic cpu_pulse(input logic [11:0] a, input logic [31:0] d, input logic rw);
    bus.i_a_addr   = a;
    bus.i_a_dwrite = d;
    bus.i_a_rw     = rw;
    bus.i_a_stb    = 1'b1;
    tick();
    bus.i_a_stb    = 1'b0;
  endtask

  task automatic wb_xfer(input logic [11:0] a, input logic [31:0] d, input logic we);
    logic got;
    got = 1'b0;
    bus.i_wb_adr = a;
    bus.i_wb_dat = d;
    bus.i_wb_we  = we;
    bus.i_wb_cyc = 1'b1;
    bus.i_wb_stb = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus.o_wb_ack) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wb_wait: no o_wb_ack for adr %h within 40 cycles", a);
    end
    @(posedge i_clk);
    #1;
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
  endtask

  // BRAM model: acks one cycle after a strobe; spur_cnt requests an unsolicited ack.
  initial begin
    logic [11:0] a;
    int          spur_seen;
    spur_seen     = 0;
    bus.i_s_ack   = 1'b0;
    bus.i_s_dread = 32'h0;
    forever begin
      @(negedge i_clk);
      if (bus.o_s_stb && bram_on) begin
        a = bus.o_s_addr;
        @(posedge i_clk); #1;
        bus.i_s_ack   = 1'b1;
        bus.i_s_dread = (a == 12'h104) ? 32'hDEAD_BEEF : {20'hC0DE0, a};
        @(posedge i_clk); #1;
        bus.i_s_ack   = 1'b0;
        bus.i_s_dread = 32'h0;
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        @(posedge i_clk); #1;
        bus.i_s_ack   = 1'b1;
        bus.i_s_dread = 32'hBAD0_BAD0;
        @(posedge i_clk); #1;
        bus.i_s_ack   = 1'b0;
        bus.i_s_dread = 32'h0;
      end
    end
  end

  // Monitor: every DUT output event must match the head of its queue.
  initial begin
    s_exp_t se;
    a_exp_t ae;
    w_exp_t we;
    int     oc;
    forever begin
      @(negedge i_clk);
      if (bus.o_s_stb) begin
        if (s_q.size() == 0) begin
          total++; bad++;
          $display("FAIL s_stb_extra: got strobe addr %h want none (cyc %0d)", bus.o_s_addr, cyc);
        end else begin
          se = s_q.pop_front();
          chk("s_req", {19'h0, bus.o_s_addr, bus.o_s_rw, bus.o_s_dwrite}, {19'h0, se.addr, se.rw, se.wdat});
          chk("s_stb_cyc", 64'(cyc), 64'(se.cyc));
        end
      end
      if (bus.o_a_ack) begin
        if (a_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_ack_extra: got ack data %h want none (cyc %0d)", bus.o_a_dread, cyc);
        end else begin
          ae = a_q.pop_front();
          chk("a_resp", {31'h0, bus.o_a_err, bus.o_a_dread}, {31'h0, ae.err, ae.dat});
          chk("a_ack_cyc", 64'(cyc), 64'(ae.cyc));
        end
      end
      if (bus.o_wb_ack) begin
        if (w_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wb_ack_extra: got ack data %h want none (cyc %0d)", bus.o_wb_dat, cyc);
        end else begin
          we = w_q.pop_front();
          chk("wb_dat", 64'(bus.o_wb_dat), 64'(we.dat));
          chk("wb_ack_cyc", 64'(cyc), 64'(we.cyc));
        end
      end
      if (bus.o_a_ovf) begin
        if (ovf_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ovf_extra: got o_a_ovf=1 want 0 (cyc %0d)", cyc);
        end else begin
          oc = ovf_q.pop_front();
          chk("ovf_cyc", 64'(cyc), 64'(oc));
        end
      end
    end
  end

  initial begin
    int c0;
    total = 0; bad = 0; bram_on = 1'b1; spur_cnt = 0;
    i_reset_n      = 1'b1;
    bus.i_a_addr   = '0; bus.i_a_dwrite = '0; bus.i_a_rw = 1'b0; bus.i_a_stb = 1'b0;
    bus.i_wb_cyc   = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    bus.i_wb_adr   = '0; bus.i_wb_dat = '0;
    #1 i_reset_n = 1'b0;
    tick(); tick();
    chk_zero("reset");
    i_reset_n = 1'b1;
    tick(); tick();

    // Uncontended CPU read
    c0 = cyc;
    push_s(12'h104, 32'h0, 1'b0, c0 + 1);
    push_a(32'hDEAD_BEEF, 1'b0, c0 + 3);
    cpu_pulse(12'h104, 32'h0, 1'b0);
    repeat (6) tick();

    // Simultaneous CPU write and WB read straight after reset: CPU wins
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    tick();
    c0 = cyc;
    push_s(12'h020, 32'h1122_3344, 1'b1, c0 + 1);
    push_s(12'h040, 32'h0000_0055, 1'b0, c0 + 4);
    push_a(32'hC0DE_0020, 1'b0, c0 + 3);
    push_w(32'hC0DE_0040, c0 + 6);
    fork
      wb_xfer(12'h040, 32'h0000_0055, 1'b0);
      cpu_pulse(12'h020, 32'h1122_3344, 1'b1);
    join
    repeat (4) tick();

    // WB stream against three back-to-back CPU strobes: alternation, pending, one overflow
    c0 = cyc;
    push_s(12'h010, 32'h0000_0A00, 1'b0, c0 + 1);
    push_s(12'h080, 32'h0000_0B00, 1'b0, c0 + 4);
    push_s(12'h014, 32'h0000_0A11, 1'b1, c0 + 7);
    push_s(12'h084, 32'h0000_0B11, 1'b1, c0 + 10);
    push_s(12'h088, 32'h0000_0B22, 1'b0, c0 + 14);
    push_a(32'hC0DE_0010, 1'b0, c0 + 3);
    push_a(32'hC0DE_0014, 1'b0, c0 + 9);
    push_w(32'hC0DE_0080, c0 + 6);
    push_w(32'hC0DE_0084, c0 + 12);
    push_w(32'hC0DE_0088, c0 + 16);
    ovf_q.push_back(c0 + 3);
    fork
      begin
        wb_xfer(12'h080, 32'h0000_0B00, 1'b0);
        wb_xfer(12'h084, 32'h0000_0B11, 1'b1);
        wb_xfer(12'h088, 32'h0000_0B22, 1'b0);
      end
      begin
        cpu_pulse(12'h010, 32'h0000_0A00, 1'b0);
        cpu_pulse(12'h014, 32'h0000_0A11, 1'b1);
        cpu_pulse(12'h018, 32'h0000_0A22, 1'b0);
      end
    join
    repeat (4) tick();

    // Slave never acks: error completion after 15 WAIT cycles, then back in IDLE
    bram_on = 1'b0;
    c0 = cyc;
    push_s(12'h200, 32'h0, 1'b0, c0 + 1);
    push_a(32'h0, 1'b1, c0 + 17);
    push_s(12'h204, 32'h0, 1'b0, c0 + 18);
    push_a(32'hC0DE_0204, 1'b0, c0 + 20);
    cpu_pulse(12'h200, 32'h0, 1'b0);
    tick(); tick();
    bram_on = 1'b1;
    while (cyc < c0 + 17) tick();
    cpu_pulse(12'h204, 32'h0, 1'b0);
    repeat (6) tick();

    // Unsolicited slave ack while IDLE must not produce any master ack
    spur_cnt = spur_cnt + 1;
    repeat (5) tick();

    // WB host abandons its cycle during WAIT; a later request is served normally
    c0 = cyc;
    push_s(12'h300, 32'h0000_0077, 1'b0, c0 + 1);
    push_s(12'h304, 32'h0000_0078, 1'b0, c0 + 5);
    push_w(32'hC0DE_0304, c0 + 7);
    bus.i_wb_adr = 12'h300; bus.i_wb_dat = 32'h0000_0077; bus.i_wb_we = 1'b0;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    tick(); tick();
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    tick(); tick();
    wb_xfer(12'h304, 32'h0000_0078, 1'b0);
    repeat (4) tick();

    // Async reset while the slave stalls in WAIT
    bram_on = 1'b0;
    c0 = cyc;
    push_s(12'h400, 32'h0, 1'b0, c0 + 1);
    cpu_pulse(12'h400, 32'h0, 1'b0);
    tick(); tick();
    #2 i_reset_n = 1'b0;
    #1 chk_zero("midreset");
    tick(); tick();
    i_reset_n = 1'b1;
    bram_on = 1'b1;
    repeat (20) tick();

    // last_grant back at WB after reset: simultaneous requests go CPU first
    c0 = cyc;
    push_s(12'h500, 32'h0, 1'b0, c0 + 1);
    push_s(12'h600, 32'hA1B2_C3D4, 1'b1, c0 + 4);
    push_a(32'hC0DE_0500, 1'b0, c0 + 3);
    push_w(32'hC0DE_0600, c0 + 6);
    fork
      wb_xfer(12'h600, 32'hA1B2_C3D4, 1'b1);
      cpu_pulse(12'h500, 32'h0, 1'b0);
    join
    repeat (6) tick();

    foreach (s_q[i]) begin
      total++; bad++;
      $display("FAIL s_missing: got no strobe, want addr %h at cyc %0d", s_q[i].addr, s_q[i].cyc);
    end
    foreach (a_q[i]) begin
      total++; bad++;
      $display("FAIL a_missing: got no cpu ack, want data %h at cyc %0d", a_q[i].dat, a_q[i].cyc);
    end
    foreach (w_q[i]) begin
      total++; bad++;
      $display("FAIL wb_missing: got no wb ack, want data %h at cyc %0d", w_q[i].dat, w_q[i].cyc);
    end
    foreach (ovf_q[i]) begin
      total++; bad++;
      $display("FAIL ovf_missing: got no overflow pulse, want one at cyc %0d", ovf_q[i]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
